// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 hex keypad scanner.
//   kp_state_t     - scanner FSM states
//   KEYMAP         - hex code for each key, indexed {row,col}
//   N_ROWS/N_COLS  - matrix dimensions
//   lowest_low_row - index of the lowest-numbered active-low row
package keypad_pkg;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  // Bottom row carries the '*' and '#' keys, which report as E and F.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Scanning from the top index down lets the lowest low row overwrite the rest.
  function automatic logic [1:0] lowest_low_row(input logic [N_ROWS-1:0] rows);
    lowest_low_row = 2'd0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) lowest_low_row = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
//   clk - destination clock
//   rst - asynchronous active-high reset; both stages reset to all ones
//   d   - asynchronous input bus
//   q   - synchronized output bus
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Ones at reset so released (active-low) keypad rows read as idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner and debouncer.
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   row_n     - keypad rows, active-low, asynchronous to clk
//   col_n     - column drive, active-low, one column low at a time
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle strobe when a key is accepted
//   key_held  - high from acceptance until the debounced release
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat strobes every
// REPEAT_CNT cycles while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000,
  parameter int REPEAT_CNT   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);

  // Out-of-range settings elaborate this empty block so they stand out in
  // the elaboration hierarchy; the scanner itself assumes values >= 2.
  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || REPEAT_CNT < 2) begin : g_param_out_of_range
  end

  kp_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [3:0]       rows_s;
  logic             row_high;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = (REPEAT_CNT > 2) ? $clog2(REPEAT_CNT) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  sync_2ff #(.WIDTH(N_ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (rows_s)
  );

  // Only the row that started the current key matters once scanning stops.
  assign row_high = rows_s[row_idx];
  assign col_n    = ~(4'b0001 << col_idx);

  // Main scanner FSM: one shared counter serves the scan tick and both
  // debounce windows, and it is cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      cnt       <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (rows_s == 4'hF) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              row_idx <= lowest_low_row(rows_s);
              state   <= DEBOUNCE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_high) begin
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt == DEB_LAST) begin
            cnt       <= '0;
            key_code  <= KEYMAP[{row_idx, col_idx}];
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (row_high) begin
            cnt   <= '0;
            state <= RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            key_valid <= 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (!row_high) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == DEB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            col_idx  <= col_idx + 2'd1;
            state    <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= SCAN;
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Repeat timer runs only while the key stays in HELD; any other cycle,
  // including the return from RELEASE, restarts it from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (state == HELD && !row_high) begin
      if (rep_cnt == REP_LAST) rep_cnt <= '0;
      else                     rep_cnt <= rep_cnt + 1'b1;
    end else begin
      rep_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner.
// A behavioural keypad pulls the chosen rows low whenever the pressed key's
// column is driven. Build with KEYPAD_REPEAT_EN to exercise auto-repeat.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int REPEAT_CNT   = 16;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       key_on   = 1'b0;
  logic [3:0] key_rows = 4'h0;
  logic [1:0] key_col  = 2'd0;

  int checks     = 0;
  int failures   = 0;
  int t          = 0;
  int valid_seen = 0;
  int valid_base = 0;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_CNT   (REPEAT_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Keypad model: pressed rows read low only while their column is driven.
  assign row_n = (key_on && !col_n[key_col]) ? ~key_rows : 4'hF;

  // Count every cycle the strobe is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (key_valid === 1'b1) valid_seen++;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
    t++;
  endtask

  task automatic stepTo(input int target);
    while (t < target) step();
  endtask

  task automatic applyStimulus(input logic on, input logic [3:0] rows, input logic [1:0] col);
    key_on   = on;
    key_rows = rows;
    key_col  = col;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [3:0] exp_col;
    logic [1:0] ci;

    // Reset with no keys.
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_col_n", 32'(col_n), 32'h0000000E);
    end
    checkOutput("rst_key_code", 32'(key_code), 32'h0);
    checkOutput("rst_key_valid", 32'(key_valid), 32'h0);
    checkOutput("rst_key_held", 32'(key_held), 32'h0);
    rst = 1'b0;
    t   = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k % 4 == 0 || k == 3) begin
        ci      = 2'((k / 4) % 4);
        exp_col = ~(4'b0001 << ci);
        checkOutput($sformatf("scan_col_k%0d", k), 32'(col_n), 32'(exp_col));
      end
    end

    // Key 6 (row1,col2): DEBOUNCE entered at 28, strobe at 36, release at 56.
    valid_base = valid_seen;
    applyStimulus(1'b1, 4'b0010, 2'd2);
    stepTo(35);
    checkOutput("k6_valid_early", 32'(key_valid), 32'h0);
    stepTo(36);
    checkOutput("k6_valid", 32'(key_valid), 32'h1);
    checkOutput("k6_code", 32'(key_code), 32'h6);
    checkOutput("k6_held", 32'(key_held), 32'h1);
    step();
    checkOutput("k6_valid_one_cycle", 32'(key_valid), 32'h0);
    stepTo(56);
    applyStimulus(1'b0, 4'h0, 2'd0);
    stepTo(66);
    checkOutput("k6_held_before_release", 32'(key_held), 32'h1);
    stepTo(67);
    checkOutput("k6_held_released", 32'(key_held), 32'h0);
    checkOutput("k6_col_advanced", 32'(col_n), 32'h7);
    checkOutput("k6_valid_count", 32'(valid_seen - valid_base), 32'(1 + REP));

    // Short press of key B on column 3: abandoned debounce.
    t = 0;
    valid_base = valid_seen;
    applyStimulus(1'b1, 4'b0010, 2'd3);
    stepTo(5);
    applyStimulus(1'b0, 4'h0, 2'd0);
    stepTo(8);
    checkOutput("short_col_kept", 32'(col_n), 32'h7);
    checkOutput("short_held", 32'(key_held), 32'h0);
    checkOutput("short_code_kept", 32'(key_code), 32'h6);
    stepTo(11);
    checkOutput("short_col_still", 32'(col_n), 32'h7);
    stepTo(12);
    checkOutput("short_col_rotate", 32'(col_n), 32'hE);
    checkOutput("short_valid_count", 32'(valid_seen - valid_base), 32'h0);

    // Key 4 with a 3-cycle glitch during release debounce.
    t = 0;
    valid_base = valid_seen;
    applyStimulus(1'b1, 4'b0010, 2'd0);
    stepTo(12);
    checkOutput("k4_valid", 32'(key_valid), 32'h1);
    checkOutput("k4_code", 32'(key_code), 32'h4);
    stepTo(20);
    applyStimulus(1'b0, 4'h0, 2'd0);
    stepTo(25);
    applyStimulus(1'b1, 4'b0010, 2'd0);
    stepTo(28);
    applyStimulus(1'b0, 4'h0, 2'd0);
    stepTo(30);
    checkOutput("glitch_held", 32'(key_held), 32'h1);
    stepTo(38);
    checkOutput("glitch_held_late", 32'(key_held), 32'h1);
    stepTo(39);
    checkOutput("glitch_released", 32'(key_held), 32'h0);
    checkOutput("glitch_col_advanced", 32'(col_n), 32'hD);
    checkOutput("glitch_valid_count", 32'(valid_seen - valid_base), 32'h1);

    // Rows 0 and 3 on column 3 -> A, then reset while HELD.
    t = 0;
    valid_base = valid_seen;
    applyStimulus(1'b1, 4'b1001, 2'd3);
    stepTo(19);
    checkOutput("kA_valid_early", 32'(key_valid), 32'h0);
    stepTo(20);
    checkOutput("kA_valid", 32'(key_valid), 32'h1);
    checkOutput("kA_code", 32'(key_code), 32'hA);
    checkOutput("kA_held", 32'(key_held), 32'h1);
    stepTo(25);
    rst = 1'b1;
    #1;
    checkOutput("midrst_col_n", 32'(col_n), 32'hE);
    checkOutput("midrst_held", 32'(key_held), 32'h0);
    checkOutput("midrst_valid", 32'(key_valid), 32'h0);
    checkOutput("midrst_code", 32'(key_code), 32'h0);
    stepTo(27);
    checkOutput("midrst_col_hold", 32'(col_n), 32'hE);
    checkOutput("kA_valid_count", 32'(valid_seen - valid_base), 32'h1);
    applyStimulus(1'b0, 4'h0, 2'd0);
    rst = 1'b0;

    // Key 0 (row3,col1) held about 60 cycles past acceptance.
    t = 0;
    valid_base = valid_seen;
    applyStimulus(1'b1, 4'b1000, 2'd1);
    stepTo(15);
    checkOutput("k0_valid_early", 32'(key_valid), 32'h0);
    stepTo(16);
    checkOutput("k0_valid", 32'(key_valid), 32'h1);
    checkOutput("k0_held", 32'(key_held), 32'h1);
    step();
    checkOutput("k0_valid_one_cycle", 32'(key_valid), 32'h0);
    stepTo(32);
    checkOutput("k0_repeat_32", 32'(key_valid), 32'(REP));
    checkOutput("k0_code_32", 32'(key_code), 32'h0);
    stepTo(64);
    checkOutput("k0_repeat_64", 32'(key_valid), 32'(REP));
    stepTo(70);
    checkOutput("k0_code_70", 32'(key_code), 32'h0);
    checkOutput("k0_held_70", 32'(key_held), 32'h1);
    stepTo(76);
    applyStimulus(1'b0, 4'h0, 2'd0);
    stepTo(86);
    checkOutput("k0_held_86", 32'(key_held), 32'h1);
    stepTo(87);
    checkOutput("k0_released", 32'(key_held), 32'h0);
    stepTo(90);
    checkOutput("k0_valid_count", 32'(valid_seen - valid_base), 32'(1 + 3 * REP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
